// File: rtl/alpha_recursion.sv
// Forward-metric (alpha) recursion for the 8-state max-log-MAP SISO decoder.
// Ports: clk/rst (sync, active-high); start/init_mode/blk_len configure a
//   block; in_valid/in_ready/gamma1/gamma2 take one step of branch metrics;
//   out_valid/out_ready/alpha_out/out_idx/out_last return the alpha used with
//   that step; busy is high while running or while an output is pending.
module alpha_recursion #(
   parameter int BM_W     = 16,
   parameter int SM_W     = 21,
   parameter int OUT_W    = 16,
   parameter int INIT_NEG = -128,
   parameter int LEN_W    = 13
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   init_mode,
   input  logic [LEN_W-1:0]       blk_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [BM_W-1:0] gamma1,
   input  logic signed [BM_W-1:0] gamma2,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*OUT_W-1:0]     alpha_out,
   output logic [LEN_W-1:0]       out_idx,
   output logic                   out_last,
   output logic                   busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic signed [SM_W+1:0] SM_HI =
      {3'b000, {(SM_W-1){1'b1}}};
   localparam logic signed [SM_W+1:0] SM_LO =
      {3'b111, {(SM_W-1){1'b0}}};
   localparam logic signed [SM_W-1:0] OUT_HI =
      {{(SM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SM_W-1:0] OUT_LO =
      {{(SM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [SM_W-1:0] INIT_V = SM_W'(INIT_NEG);

   state_t state, state_next;

   logic signed [SM_W-1:0] metric [8];
   logic signed [SM_W-1:0] metric_next [8];
   logic signed [SM_W:0]   ext [8];
   logic signed [SM_W:0]   raw [8];
   logic signed [SM_W:0]   g1;
   logic signed [SM_W:0]   g2;

   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] k;
   logic             go;
   logic             accept;
   logic             last_step;

   function automatic logic signed [SM_W:0] vmax(
      input logic signed [SM_W:0] x,
      input logic signed [SM_W:0] y
   );
      return (x > y) ? x : y;
   endfunction

   function automatic logic signed [SM_W-1:0] sat_sm(
      input logic signed [SM_W+1:0] x
   );
      if (x > SM_HI)
         return SM_HI[SM_W-1:0];
      else if (x < SM_LO)
         return SM_LO[SM_W-1:0];
      else
         return x[SM_W-1:0];
   endfunction

   function automatic logic [OUT_W-1:0] sat_out(
      input logic signed [SM_W-1:0] x
   );
      if (x > OUT_HI)
         return OUT_HI[OUT_W-1:0];
      else if (x < OUT_LO)
         return OUT_LO[OUT_W-1:0];
      else
         return x[OUT_W-1:0];
   endfunction

   assign go        = start && (blk_len != '0);
   assign in_ready  = (state == RUN) && !start && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign last_step = (k == len - LEN_W'(1));
   assign busy      = (state == RUN) || out_valid;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (go)
               state_next = RUN;
         end
         RUN: begin
            if (start)
               state_next = go ? RUN : IDLE;
            else if (accept && last_step)
               state_next = IDLE;
         end
      endcase
   end

   // Trellis butterflies on one-bit-wider sums, then normalise to state 0
   // with two extra bits so the difference cannot wrap before saturation.
   always_comb begin
      g1 = {{(SM_W+1-BM_W){gamma1[BM_W-1]}}, gamma1};
      g2 = {{(SM_W+1-BM_W){gamma2[BM_W-1]}}, gamma2};
      for (int s = 0; s < 8; s++)
         ext[s] = {metric[s][SM_W-1], metric[s]};
      raw[0] = vmax(ext[0] + g1, ext[1] - g1);
      raw[1] = vmax(ext[2] - g2, ext[3] + g2);
      raw[2] = vmax(ext[4] + g2, ext[5] - g2);
      raw[3] = vmax(ext[6] - g1, ext[7] + g1);
      raw[4] = vmax(ext[0] - g1, ext[1] + g1);
      raw[5] = vmax(ext[2] + g2, ext[3] - g2);
      raw[6] = vmax(ext[4] - g2, ext[5] + g2);
      raw[7] = vmax(ext[6] + g1, ext[7] - g1);
      for (int s = 0; s < 8; s++)
         metric_next[s] = sat_sm({raw[s][SM_W], raw[s]}
                                 - {raw[0][SM_W], raw[0]});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 8; s++)
            metric[s] <= (s == 0) ? '0 : INIT_V;
         len       <= '0;
         k         <= '0;
         out_valid <= 1'b0;
         alpha_out <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else if (start) begin
         // Restart or abort: any pending output is dropped.
         out_valid <= 1'b0;
         if (go) begin
            len <= blk_len;
            k   <= '0;
            for (int s = 0; s < 8; s++)
               metric[s] <= (s == 0 || init_mode) ? '0 : INIT_V;
         end
      end else if (accept) begin
         for (int s = 0; s < 8; s++)
            alpha_out[s*OUT_W +: OUT_W] <= sat_out(metric[s]);
         out_idx   <= k;
         out_last  <= last_step;
         out_valid <= 1'b1;
         for (int s = 0; s < 8; s++)
            metric[s] <= metric_next[s];
         k <= k + LEN_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alpha_recursion.sv
// Directed bench for alpha_recursion: default widths plus an OUT_W=8 copy
// sharing the same stimulus to exercise output saturation.
module tb_alpha_recursion;

   typedef int vec_t [8];

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               init_mode;
   logic [12:0]        blk_len;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] gamma1;
   logic signed [15:0] gamma2;
   logic               out_valid;
   logic               out_ready;
   logic [127:0]       alpha_out;
   logic [12:0]        out_idx;
   logic               out_last;
   logic               busy;

   logic               in_ready8;
   logic               out_valid8;
   logic [63:0]        alpha_out8;
   logic [12:0]        out_idx8;
   logic               out_last8;
   logic               busy8;

   int checks = 0;
   int errors = 0;

   vec_t term_v = '{0, -128, -128, -128, -128, -128, -128, -128};
   vec_t zero_v = '{0, 0, 0, 0, 0, 0, 0, 0};
   vec_t t1_v   = '{0, -128, -128, -128, 0, -128, -128, -128};
   vec_t t2_v   = '{0, -128, 0, -128, 0, -128, 0, -128};
   vec_t g10_v  = '{0, -138, -138, -128, -20, -138, -138, -128};
   vec_t g10s_v = '{0, -128, -128, -128, -20, -128, -128, -128};
   vec_t p200_v = '{0, 200, 200, 0, 0, 200, 200, 0};
   vec_t p127_v = '{0, 127, 127, 0, 0, 127, 127, 0};

   alpha_recursion dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .init_mode (init_mode),
      .blk_len   (blk_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .gamma1    (gamma1),
      .gamma2    (gamma2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alpha_out (alpha_out),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   alpha_recursion #(.OUT_W(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .init_mode (init_mode),
      .blk_len   (blk_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready8),
      .gamma1    (gamma1),
      .gamma2    (gamma2),
      .out_valid (out_valid8),
      .out_ready (out_ready),
      .alpha_out (alpha_out8),
      .out_idx   (out_idx8),
      .out_last  (out_last8),
      .busy      (busy8)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] p16(input vec_t v);
      logic [127:0] r;
      r = '0;
      for (int s = 0; s < 8; s++)
         r[s*16 +: 16] = v[s][15:0];
      return r;
   endfunction

   function automatic logic [127:0] p8(input vec_t v);
      logic [127:0] r;
      r = '0;
      for (int s = 0; s < 8; s++)
         r[s*8 +: 8] = v[s][7:0];
      return r;
   endfunction

   task automatic check(input string tag,
                        input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic begin_blk(input int len, input logic mode);
      start     = 1'b1;
      blk_len   = 13'(len);
      init_mode = mode;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic step(input int a, input int b);
      in_valid = 1'b1;
      gamma1   = 16'(a);
      gamma2   = 16'(b);
      #1;
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(negedge clk);
         #1;
      end
      check("accept_wait", 128'(in_ready), 128'(1));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      init_mode = 1'b0;
      blk_len   = '0;
      in_valid  = 1'b0;
      gamma1    = '0;
      gamma2    = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_outs",
            {in_ready, out_valid, out_last, busy, out_idx}, '0);
      check("rst_alpha", alpha_out, '0);
      rst = 1'b0;
      @(negedge clk);

      // terminated start, zero gammas, K=3
      begin_blk(3, 1'b0);
      check("t_ov0", 128'(out_valid), 128'(0));
      step(0, 0);
      check("t_idx0", 128'(out_idx), 128'(0));
      check("t_a0", alpha_out, p16(term_v));
      check("t_last0", 128'(out_last), 128'(0));
      step(0, 0);
      check("t_idx1", 128'(out_idx), 128'(1));
      check("t_a1", alpha_out, p16(t1_v));
      step(0, 0);
      check("t_idx2", 128'(out_idx), 128'(2));
      check("t_a2", alpha_out, p16(t2_v));
      check("t_last2", 128'(out_last), 128'(1));
      check("t_busy2", 128'(busy), 128'(1));
      check("t_rdy_idle", 128'(in_ready), 128'(0));
      @(negedge clk);
      check("t_done_ov", 128'(out_valid), 128'(0));
      check("t_done_busy", 128'(busy), 128'(0));

      // nonzero gamma, K=2, both widths
      begin_blk(2, 1'b0);
      step(10, 0);
      check("g_a0", alpha_out, p16(term_v));
      check("g_a0_8", 128'(alpha_out8), p8(term_v));
      step(10, 0);
      check("g_a1", alpha_out, p16(g10_v));
      check("g_a1_8", 128'(alpha_out8), p8(g10s_v));
      check("g_last1", 128'(out_last), 128'(1));
      @(negedge clk);

      // backpressure: gamma 10 offered but must not be consumed
      begin_blk(3, 1'b0);
      step(0, 0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      gamma1    = 16'sd10;
      #1;
      check("bp_rdy", 128'(in_ready), 128'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_rdy_h", 128'(in_ready), 128'(0));
         check("bp_ov", 128'(out_valid), 128'(1));
         check("bp_idx", 128'(out_idx), 128'(0));
         check("bp_a", alpha_out, p16(term_v));
      end
      out_ready = 1'b1;
      step(0, 0);
      check("bp_idx1", 128'(out_idx), 128'(1));
      check("bp_a1", alpha_out, p16(t1_v));
      step(0, 0);
      check("bp_last", 128'(out_last), 128'(1));
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("bp_extra_ov", 128'(out_valid), 128'(0));
      check("bp_extra_busy", 128'(busy), 128'(0));
      in_valid = 1'b0;

      // equiprobable, zero gammas
      begin_blk(3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0);
         check("eq_idx", 128'(out_idx), 128'(i));
         check("eq_a", alpha_out, p16(zero_v));
      end
      @(negedge clk);

      // equiprobable, positive metrics and positive output saturation
      begin_blk(2, 1'b1);
      step(0, 200);
      check("ps_a0", alpha_out, p16(zero_v));
      step(0, 0);
      check("ps_a1", alpha_out, p16(p200_v));
      check("ps_a1_8", 128'(alpha_out8), p8(p127_v));
      @(negedge clk);

      // restart at idx1 of K=4
      begin_blk(4, 1'b0);
      step(0, 0);
      step(0, 0);
      check("rs_pre_idx", 128'(out_idx), 128'(1));
      start     = 1'b1;
      blk_len   = 13'd4;
      init_mode = 1'b0;
      #1;
      check("rs_rdy", 128'(in_ready), 128'(0));
      @(negedge clk);
      start = 1'b0;
      check("rs_ov", 128'(out_valid), 128'(0));
      check("rs_busy", 128'(busy), 128'(1));
      step(0, 0);
      check("rs_idx", 128'(out_idx), 128'(0));
      check("rs_a", alpha_out, p16(term_v));

      // zero length: abort from RUN, then ignored from IDLE
      start   = 1'b1;
      blk_len = '0;
      @(negedge clk);
      start = 1'b0;
      check("zl_abort_busy", 128'(busy), 128'(0));
      check("zl_abort_ov", 128'(out_valid), 128'(0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("zl_idle_busy", 128'(busy), 128'(0));

      // reset mid-block
      begin_blk(4, 1'b0);
      step(0, 0);
      check("mr_ov", 128'(out_valid), 128'(1));
      rst      = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check("mr_outs",
            {in_ready, out_valid, out_last, busy, out_idx}, '0);
      check("mr_alpha", alpha_out, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("mr_after_ov", 128'(out_valid), 128'(0));
      check("mr_after_busy", 128'(busy), 128'(0));
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
